tx_link_ctrl: RTL and testbench

TX_LINK_CTRL -- requirements
Module: tx_link_ctrl

---
 rtl/tx_link_ctrl.sv | 136 +++++++++++++
 tb/tb_tx_link_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_ctrl.sv
// Transmit link controller ahead of an 8b/10b encoder: alignment commas, SOF/EOF
// framing, underrun filler and periodic comma insertion so the receiver stays locked.
module tx_link_ctrl #(
  parameter int ALIGN_CNT    = 16,
  parameter int COMMA_PERIOD = 256
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  input  logic       TX_LAST,
  output logic       TX_READY,
  output logic [7:0] ENC_DIN,
  output logic       ENC_KIN,
  output logic       LINK_UP
);

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SOF   = 8'hFB;
  localparam logic [7:0] K_EOF   = 8'hFD;

  localparam logic [2:0] ST_ALIGN = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SOF   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_SKIP  = 3'd4;
  localparam logic [2:0] ST_EOF   = 3'd5;

  localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_CNT - 1);
  localparam logic [9:0] RUN_MAX    = 10'(COMMA_PERIOD);
  localparam logic [9:0] RUN_DUE    = 10'(COMMA_PERIOD - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [9:0] sat_inc_run(input logic [9:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + 10'd1;
  endfunction

  logic [2:0] state_q, state_d;
  logic [7:0] align_cnt_q, align_cnt_d;
  logic [9:0] run_q, run_d;
  logic [7:0] din_q, din_d;
  logic       kin_q, kin_d;
  logic       link_up_q, link_up_d;
  logic [9:0] run_next;
  logic       comma_due;
  logic       xfer;

  assign comma_due = (run_q == RUN_DUE);
  assign run_next  = sat_inc_run(run_q);
  assign TX_READY  = (state_q == ST_DATA) && EN && !comma_due;
  assign xfer      = TX_VALID && TX_READY;

  // Each state's word is registered at the end of its cycle, so the output trails
  // the state by one clock; SKIP is entered on the word that makes the comma due.
  always_comb begin
    state_d     = state_q;
    align_cnt_d = 8'd0;
    din_d       = K_COMMA;
    kin_d       = 1'b1;
    link_up_d   = link_up_q;

    if (!EN && (state_q != ST_ALIGN)) begin
      state_d   = ST_ALIGN;
      link_up_d = 1'b0;
    end else begin
      case (state_q)
        ST_ALIGN: begin
          link_up_d = 1'b0;
          if (EN) begin
            if (align_cnt_q >= ALIGN_LAST) begin
              state_d   = ST_IDLE;
              link_up_d = 1'b1;
            end else begin
              align_cnt_d = sat_inc8(align_cnt_q);
            end
          end
        end
        ST_IDLE: begin
          if (TX_VALID) state_d = ST_SOF;
        end
        ST_SOF: begin
          din_d   = K_SOF;
          state_d = (run_next >= RUN_DUE) ? ST_SKIP : ST_DATA;
        end
        ST_DATA: begin
          if (xfer) begin
            din_d = TX_DATA;
            kin_d = 1'b0;
            if (TX_LAST)                   state_d = ST_EOF;
            else if (run_next >= RUN_DUE)  state_d = ST_SKIP;
          end
        end
        ST_SKIP: begin
          state_d = ST_DATA;
        end
        ST_EOF: begin
          din_d   = K_EOF;
          state_d = ST_IDLE;
        end
        default: begin
          state_d   = ST_ALIGN;
          link_up_d = 1'b0;
        end
      endcase
    end

    run_d = (kin_d && (din_d == K_COMMA)) ? 10'd0 : run_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_ALIGN;
      align_cnt_q <= 8'd0;
      run_q       <= 10'd0;
      din_q       <= K_COMMA;
      kin_q       <= 1'b1;
      link_up_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      align_cnt_q <= align_cnt_d;
      run_q       <= run_d;
      din_q       <= din_d;
      kin_q       <= kin_d;
      link_up_q   <= link_up_d;
    end
  end

  assign ENC_DIN = din_q;
  assign ENC_KIN = kin_q;
  assign LINK_UP = link_up_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Bench for tx_link_ctrl: directed framing/abort/reset scenarios plus random packets,
// all scored by a word-level model of the link rules.
module tb_tx_link_ctrl;

  localparam int PER_A = 256;
  localparam int PER_B = 8;

  logic       clk, rst_n, en, valid, last, sel;
  logic [7:0] data;
  logic       ready_a, kin_a, link_a, ready_b, kin_b, link_b;
  logic [7:0] din_a, din_b;
  logic       ready, kin, link;
  logic [7:0] din;

  int n_cmp = 0;
  int n_bad = 0;
  int n_ready;
  int run_len;
  bit prev_last, prev_fd;
  logic [8:0] log_w[$];
  bit         rdy_log[$];

  tx_link_ctrl u_dut_a (
    .CLK(clk), .RST_N(rst_n), .EN(en), .TX_DATA(data), .TX_VALID(valid & ~sel),
    .TX_LAST(last), .TX_READY(ready_a), .ENC_DIN(din_a), .ENC_KIN(kin_a), .LINK_UP(link_a)
  );

  tx_link_ctrl #(.ALIGN_CNT(4), .COMMA_PERIOD(PER_B)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .EN(en), .TX_DATA(data), .TX_VALID(valid & sel),
    .TX_LAST(last), .TX_READY(ready_b), .ENC_DIN(din_b), .ENC_KIN(kin_b), .LINK_UP(link_b)
  );

  assign ready = sel ? ready_b : ready_a;
  assign din   = sel ? din_b   : din_a;
  assign kin   = sel ? kin_b   : kin_a;
  assign link  = sel ? link_b  : link_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input logic s);
    sel = s; run_len = 0; prev_last = 0; prev_fd = 0;
  endtask

  // One clock: sample the handshake mid-cycle, then score the word that the edge produced.
  task automatic tick(output bit acc);
    bit r, lk, al;
    logic [7:0] ab;
    int per;
    #3;
    r = ready; lk = link; acc = valid && r; ab = data; al = last;
    if (r) begin
      n_ready++;
      chk("ready_implies_link", 32'(lk), 32'd1);
    end
    @(posedge clk); #1;
    log_w.push_back({kin, din});
    rdy_log.push_back(r);
    if (acc) chk("sb_data_word", 32'({kin, din}), 32'({1'b0, ab}));
    else     chk("sb_k_word", 32'(kin), 32'd1);
    if (prev_last) chk("sb_eof_after_last", 32'({kin, din}), 32'h1FD);
    if (prev_fd)   chk("sb_comma_after_eof", 32'({kin, din}), 32'h1BC);
    if (kin && din == 8'hBC) run_len = 0;
    else                     run_len++;
    per = sel ? PER_B : PER_A;
    chk("sb_run_bound", 32'(run_len <= per), 32'd1);
    prev_last = acc && al;
    prev_fd   = kin && (din == 8'hFD);
  endtask

  task automatic wait_link(input int exp_n, input string tag);
    int n = 0;
    bit acc;
    valid = 0; last = 0;
    while (!link && n < 300) begin
      tick(acc);
      n++;
      chk("align_comma", 32'({kin, din}), 32'h1BC);
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic send_pkt(input logic [7:0] b[$], input int gap_at, input int gap_len,
                          input int gap_pct);
    int idx = 0, gaps = 0, cyc = 0;
    bit acc, seen_fd = 0, done = 0;
    log_w.delete(); rdy_log.delete(); n_ready = 0;
    while (!done && cyc < 400) begin
      if (idx < b.size()) begin
        if (idx == gap_at && gaps < gap_len) begin valid = 0; gaps++; end
        else if (gap_pct > 0 && $urandom_range(99) < gap_pct) valid = 0;
        else valid = 1;
        data = valid ? b[idx] : 8'($urandom);
        last = valid ? (idx == b.size() - 1) : 1'($urandom);
      end else begin
        valid = 0; last = 0;
      end
      tick(acc);
      if (acc) idx++;
      cyc++;
      if (seen_fd) done = 1;
      if (kin && din == 8'hFD) seen_fd = 1;
    end
    valid = 0; last = 0;
    chk("pkt_completed", 32'(done), 32'd1);
  endtask

  function automatic int find_word(input logic [8:0] w);
    foreach (log_w[k]) if (log_w[k] == w) return k;
    return -1;
  endfunction

  task automatic chk_seq(input string tag, input logic [8:0] exp[$]);
    int f = find_word(9'h1FB);
    logic [8:0] got;
    chk("seq_sof_found", 32'(f >= 0), 32'd1);
    foreach (exp[i]) begin
      got = (f >= 0 && f + i < log_w.size()) ? log_w[f + i] : 9'h000;
      chk(tag, 32'(got), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [7:0] b[$];
    bit acc;
    int idx, c, f, e, skips, j, nd;

    rst_n = 0; en = 1; valid = 0; last = 0; data = 8'h00;
    set_sel(0);
    repeat (3) tick(acc);
    chk("rst_din", 32'(din), 32'hBC);
    chk("rst_kin", 32'(kin), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_link", 32'(link), 32'd0);

    // Alignment after reset release, then commas while idle.
    rst_n = 1;
    wait_link(16, "align_cycles_after_reset");
    repeat (3) begin
      tick(acc);
      chk("idle_comma", 32'({kin, din}), 32'h1BC);
      chk("idle_link", 32'(link), 32'd1);
    end

    // Basic 4-byte packet.
    b = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(b, -1, 0, 0);
    chk_seq("pkt4_word", '{9'h1FB, 9'h011, 9'h022, 9'h033, 9'h044, 9'h1FD, 9'h1BC});
    chk("pkt4_ready_cycles", 32'(n_ready), 32'd4);

    // Two-cycle underrun mid-packet.
    b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_pkt(b, 2, 2, 0);
    chk_seq("underrun_word", '{9'h1FB, 9'h0A1, 9'h0A2, 9'h1BC, 9'h1BC, 9'h0A3, 9'h0A4,
                               9'h0A5, 9'h1FD, 9'h1BC});

    // EN low coinciding with TX_VALID in IDLE.
    en = 0; valid = 1; data = 8'h55; last = 0;
    tick(acc);
    chk("en_vs_valid_word", 32'({kin, din}), 32'h1BC);
    chk("en_vs_valid_link", 32'(link), 32'd0);
    en = 1;
    wait_link(16, "realign_after_idle_drop");

    // Comma insertion with a short period.
    set_sel(1);
    b.delete();
    for (int i = 0; i < 20; i++) b.push_back(8'(8'h60 + i));
    send_pkt(b, -1, 0, 0);
    f = find_word(9'h1FB);
    e = find_word(9'h1FD);
    chk("p8_framing", 32'(f >= 0 && e > f), 32'd1);
    skips = 0; j = 0;
    for (int k = f + 1; k < e; k++) begin
      if (log_w[k] == 9'h1BC) begin
        skips++;
        chk("p8_skip_ready_low", 32'(rdy_log[k]), 32'd0);
      end else if (!log_w[k][8]) begin
        if (j < b.size()) chk("p8_byte_order", 32'(log_w[k][7:0]), 32'(b[j]));
        j++;
      end
    end
    chk("p8_byte_count", 32'(j), 32'd20);
    chk("p8_skip_present", 32'(skips >= 2), 32'd1);

    // Random packets against the scoreboard on both period settings.
    for (int p = 0; p < 12; p++) begin
      set_sel(p >= 8 ? 1'b0 : 1'b1);
      b.delete();
      for (int i = 0, n = $urandom_range(1, 14); i < n; i++) b.push_back(8'($urandom));
      send_pkt(b, -1, 0, 25);
      nd = 0;
      foreach (log_w[k]) if (!log_w[k][8]) nd++;
      chk("rand_byte_count", 32'(nd), 32'(b.size()));
      repeat ($urandom_range(0, 3)) tick(acc);
    end

    // EN dropped after the second data byte.
    set_sel(0);
    b = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    idx = 0; c = 0; last = 0;
    while (idx < 2 && c < 50) begin
      valid = 1; data = b[idx];
      tick(acc);
      if (acc) idx++;
      c++;
    end
    chk("abort_two_accepted", 32'(idx), 32'd2);
    data = b[2]; en = 0;
    #1;
    chk("abort_ready_now", 32'(ready), 32'd0);
    tick(acc);
    chk("abort_word", 32'({kin, din}), 32'h1BC);
    chk("abort_link", 32'(link), 32'd0);
    chk("abort_no_accept", 32'(acc), 32'd0);
    tick(acc);
    chk("abort_still_comma", 32'({kin, din}), 32'h1BC);
    en = 1;
    wait_link(16, "realign_after_abort");

    // Asynchronous reset pulse in the middle of DATA.
    b = '{8'hD1, 8'hD2, 8'hD3};
    idx = 0; c = 0;
    while (idx < 2 && c < 50) begin
      valid = 1; data = b[idx];
      tick(acc);
      if (acc) idx++;
      c++;
    end
    chk("rstmid_two_accepted", 32'(idx), 32'd2);
    data = b[2];
    #3 rst_n = 0;
    #1;
    chk("rstmid_din", 32'(din), 32'hBC);
    chk("rstmid_kin", 32'(kin), 32'd1);
    chk("rstmid_ready", 32'(ready), 32'd0);
    chk("rstmid_link", 32'(link), 32'd0);
    tick(acc);
    rst_n = 1;
    wait_link(16, "realign_after_reset_pulse");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
